mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM pipeline register and performs load/store accesses to the data memory over a request/grant/response handshake. It aligns store data and byte enables, and aligns and extends load data. It stalls upstream stages while an access is outstanding, and drives the registered MEM/WB outputs consumed by writeback.

## Interface
Parameters:
- none; widths fixed at 32-bit XLEN.

Ports:
- clk  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- valid_m  in  1  instruction in MEM is valid.
- DataMemoryAddress_m  in  32  ALU result / effective address.
- WD_m  in  32  store data (rs2).
- PC4_m  in  32  PC+4 for link writeback.
- ctrl_m  in  bundle_decode_t  uses MemW, MemR, MemSize, MemUnsigned, ResultSelect, RegW.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address, bits [1:0] = 0.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load word.
- stall_m  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- valid_w  out  1  MEM/WB valid.
- Result_w  out  32  writeback value.
- ctrl_w  out  bundle_decode_t  control forwarded to WB.
- misalign_w  out  1  misaligned-access flag (present only with MEM_MISALIGN_TRAP_EN).

## Operation
- Access pending = valid_m & (MemR | MemW) & not misaligned.
- FSM states:
  - IDLE
    - pending: dmem_req=1.
    - gnt=0 → REQ, stall_m=1.
    - gnt=1 & store → stay IDLE, stall_m=0.
    - gnt=1 & load → WAIT, stall_m=1.
  - REQ
    - dmem_req=1, outputs held stable (EX/MEM frozen).
    - gnt: store → IDLE with stall_m=0 that cycle; load → WAIT with stall_m=1.
  - WAIT
    - dmem_req=0, stall_m=1 until dmem_rvalid.
    - On rvalid → IDLE, stall_m=0 that cycle.
- Ignored inputs: rvalid outside WAIT; gnt in WAIT.
- Store alignment (off = addr[1:0]):
  - B: wdata={4{WD[7:0]}}, be=4'b0001<<off.
  - H: wdata={2{WD[15:0]}}, be=4'b0011<<off.
  - W: wdata=WD, be=4'b1111.
- Loads: be=4'b1111, dmem_we=0.
- Load alignment: shifted = rdata >> (8*off); B/H sign-extended unless MemUnsigned, then zero-extended.
- Misaligned: H with addr[0]=1; W with addr[1:0]≠0. Never issued to memory.
- Result_w source by ResultSelect:
  - RESULT_ALU: address.
  - RESULT_MEM: aligned load data.
  - RESULT_PC4: PC4_m.
- MEM/WB register loads when stall_m=0: valid_w=valid_m, ctrl_w=ctrl_m, Result_w as selected. When stall_m=1 it loads a bubble (valid_w=0, ctrl_w.RegW=0).

## Timing
- Reset values:
  - state IDLE.
  - valid_w=0, Result_w=0.
  - ctrl_w: all zero, ResultSelect=RESULT_ALU.
  - misalign_w=0.
  - dmem_req/stall_m deassert immediately (combinational from state and inputs).
- Store: 0 stall cycles if gnt same cycle as request.
- Load: minimum 1 stall cycle (gnt cycle + rvalid next cycle). Result visible on Result_w the edge after rvalid.
- Each extra cycle of gnt or rvalid delay adds one stall cycle.
- Reset mid-access: FSM → IDLE asynchronously; any late rvalid is ignored.
- Non-memory instructions pass through in 1 cycle with no stall.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned access suppressed (no dmem_req, no stall).
  - Registered misalign_w=1 alongside the instruction.
  - ctrl_w.RegW forced to 0.
- Undefined:
  - misalign_w port absent.
  - Misaligned addresses are force-aligned (H clears addr[0], W clears addr[1:0]) and issued normally.

## Structure
- Pkg holds:
  - bundle_decode_t, extended with MemR, MemSize, MemUnsigned, RegW.
  - mem_size_t {SIZE_B, SIZE_H, SIZE_W}.
  - result_select_t (RESULT_ALU, RESULT_MEM, RESULT_PC4).
  - mem_state_t {MS_IDLE, MS_REQ, MS_WAIT}.
- One sub-module, lsu_align: combinational store lane/byte-enable generation and load shift/extend. FSM and MEM/WB register stay in the top.

## Test plan
- SW addr 0x100, WD 0xDEADBEEF, gnt same cycle → be=4'b1111, wdata=0xDEADBEEF, stall_m never asserted.
- SB addr 0x103, WD 0x000000A5, gnt delayed 2 cycles → be=4'b1000, wdata=0xA5A5A5A5, stall_m high exactly 2 cycles.
- LB addr 0x102, rdata 0x0080FF00, rvalid 1 cycle after gnt → Result_w=0xFFFFFF80. Same with LBU → 0x00000080. stall_m high 1 cycle.
- LH addr 0x101 with MEM_MISALIGN_TRAP_EN → no dmem_req, misalign_w=1, ctrl_w.RegW=0. Without the macro → dmem_addr=0x100 and the access is issued.
- Reset asserted in WAIT, rvalid arrives after release → state IDLE, valid_w=0, Result_w unchanged at 0.
- ADD with ResultSelect=RESULT_ALU, address 0x1234 → Result_w=0x1234 next edge, no dmem_req.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared types for the memory-access (MEM) pipeline stage:
//   mem_size_t       - access width (byte / half / word)
//   result_select_t  - writeback result source
//   mem_state_t      - data-memory handshake FSM state
//   bundle_decode_t  - decoded control bundle carried down the pipeline
// Helper functions classify and force-align sub-word offsets.
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'd0,
    RESULT_MEM = 2'd1,
    RESULT_PC4 = 2'd2
  } result_select_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_WAIT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic           MemW;
    logic           MemR;
    mem_size_t      MemSize;
    logic           MemUnsigned;
    result_select_t ResultSelect;
    logic           RegW;
  } bundle_decode_t;

  // All-zero control bundle; ResultSelect encodes RESULT_ALU as zero.
  localparam bundle_decode_t CTRL_RESET = '{
    MemW:         1'b0,
    MemR:         1'b0,
    MemSize:      SIZE_B,
    MemUnsigned:  1'b0,
    ResultSelect: RESULT_ALU,
    RegW:         1'b0
  };

  // True when the byte offset is not naturally aligned for the access size.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_H:  mis = off[0];
      SIZE_W:  mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Drops the low offset bits that a natural alignment would forbid.
  function automatic logic [1:0] force_align(input mem_size_t size, input logic [1:0] off);
    logic [1:0] res;
    case (size)
      SIZE_H:  res = {off[1], 1'b0};
      SIZE_W:  res = 2'b00;
      default: res = off;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_access_stage_lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the MEM stage.
//   size_i, unsigned_i : access width and load extension mode
//   off_i              : byte offset within the word (already aligned to size)
//   wd_i               : raw store data (rs2)
//   rdata_i            : raw load word from data memory
//   wdata_o            : lane-replicated store data
//   be_o               : store byte enables
//   load_data_o        : shifted and sign/zero-extended load value
// -----------------------------------------------------------------------------
module lsu_align
  import mem_access_stage_pkg::*;
(
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted_s;

  // Store path: replicate the sub-word into every lane, enable only the target bytes.
  always_comb begin
    wdata_o = wd_i;
    be_o    = 4'b1111;
    case (size_i)
      SIZE_B: begin
        wdata_o = {4{wd_i[7:0]}};
        be_o    = 4'b0001 << off_i;
      end
      SIZE_H: begin
        wdata_o = {2{wd_i[15:0]}};
        be_o    = 4'b0011 << off_i;
      end
      SIZE_W: begin
        wdata_o = wd_i;
        be_o    = 4'b1111;
      end
      default: begin
        wdata_o = wd_i;
        be_o    = 4'b1111;
      end
    endcase
  end

  // Load path: move the addressed bytes to bit 0, then extend.
  assign shifted_s = rdata_i >> {off_i, 3'b000};

  // Load extension by access width and signedness.
  always_comb begin
    load_data_o = shifted_s;
    case (size_i)
      SIZE_B: begin
        if (unsigned_i) begin
          load_data_o = {24'h00_0000, shifted_s[7:0]};
        end else begin
          load_data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      SIZE_H: begin
        if (unsigned_i) begin
          load_data_o = {16'h0000, shifted_s[15:0]};
        end else begin
          load_data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      SIZE_W: begin
        load_data_o = shifted_s;
      end
      default: begin
        load_data_o = shifted_s;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the 5-stage pipeline: issues loads/stores to data memory over a
// req/gnt/rvalid handshake, stalls upstream while an access is outstanding and
// drives the registered MEM/WB outputs.
//
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   valid_m, ctrl_m       : instruction valid / decoded control in MEM
//   DataMemoryAddress_m   : ALU result / effective address
//   WD_m, PC4_m           : store data, link value
//   dmem_req/we/addr/wdata/be, dmem_gnt/rvalid/rdata : data-memory handshake
//   stall_m               : freezes PC, IF/ID, ID/EX, EX/MEM
//   valid_w, Result_w, ctrl_w : MEM/WB register
//   misalign_w            : misaligned-access flag (only with MEM_MISALIGN_TRAP_EN)
//
// Build option MEM_MISALIGN_TRAP_EN: when defined, misaligned accesses are not
// issued, are flagged on misalign_w and lose their register write. When
// undefined, misaligned offsets are force-aligned and issued normally.
// -----------------------------------------------------------------------------
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           valid_m,
  input  logic [31:0]    DataMemoryAddress_m,
  input  logic [31:0]    WD_m,
  input  logic [31:0]    PC4_m,
  input  bundle_decode_t ctrl_m,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [31:0]    dmem_addr,
  output logic [31:0]    dmem_wdata,
  output logic [3:0]     dmem_be,
  input  logic           dmem_gnt,
  input  logic           dmem_rvalid,
  input  logic [31:0]    dmem_rdata,
  output logic           stall_m,
  output logic           valid_w,
  output logic [31:0]    Result_w,
  output bundle_decode_t ctrl_w
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic           misalign_w
`endif
);

  mem_state_t     state_q, state_d;
  logic           req_s, stall_s;
  logic           mem_op_s, pending_s, trap_s;
  logic [1:0]     off_s;
  logic [31:0]    wdata_s, load_data_s, result_sel_s;
  logic [3:0]     be_s;

  logic           valid_w_q, valid_w_d;
  logic [31:0]    result_w_q, result_w_d;
  bundle_decode_t ctrl_w_q, ctrl_w_d;
  logic           misalign_w_q, misalign_w_d;

  assign mem_op_s = valid_m & (ctrl_m.MemR | ctrl_m.MemW);
  assign off_s    = force_align(ctrl_m.MemSize, DataMemoryAddress_m[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_s    = mem_op_s & is_misaligned(ctrl_m.MemSize, DataMemoryAddress_m[1:0]);
  assign pending_s = mem_op_s & ~trap_s;
`else
  assign trap_s    = 1'b0;
  assign pending_s = mem_op_s;
`endif

  lsu_align u_lsu_align (
    .size_i      (ctrl_m.MemSize),
    .unsigned_i  (ctrl_m.MemUnsigned),
    .off_i       (off_s),
    .wd_i        (WD_m),
    .rdata_i     (dmem_rdata),
    .wdata_o     (wdata_s),
    .be_o        (be_s),
    .load_data_o (load_data_s)
  );

  // Handshake FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake FSM next state; gnt is ignored in WAIT and rvalid outside it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE: begin
        if (pending_s) begin
          if (dmem_gnt) begin
            state_d = ctrl_m.MemW ? MS_IDLE : MS_WAIT;
          end else begin
            state_d = MS_REQ;
          end
        end else begin
          state_d = MS_IDLE;
        end
      end
      MS_REQ: begin
        if (dmem_gnt) begin
          state_d = ctrl_m.MemW ? MS_IDLE : MS_WAIT;
        end else begin
          state_d = MS_REQ;
        end
      end
      MS_WAIT: begin
        if (dmem_rvalid) begin
          state_d = MS_IDLE;
        end else begin
          state_d = MS_WAIT;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // Handshake FSM outputs: a granted store releases the stall in the grant cycle,
  // a load holds it until the data returns.
  always_comb begin
    req_s   = 1'b0;
    stall_s = 1'b0;
    case (state_q)
      MS_IDLE: begin
        req_s   = pending_s;
        stall_s = pending_s & (~dmem_gnt | ~ctrl_m.MemW);
      end
      MS_REQ: begin
        req_s   = 1'b1;
        stall_s = ~dmem_gnt | ~ctrl_m.MemW;
      end
      MS_WAIT: begin
        req_s   = 1'b0;
        stall_s = ~dmem_rvalid;
      end
      default: begin
        req_s   = 1'b0;
        stall_s = 1'b0;
      end
    endcase
  end

  // Gating with reset drops req/stall the moment reset asserts, before the FSM clocks.
  assign dmem_req   = req_s & reset;
  assign stall_m    = stall_s & reset;
  assign dmem_we    = dmem_req & ctrl_m.MemW;
  assign dmem_addr  = {DataMemoryAddress_m[31:2], 2'b00};
  assign dmem_wdata = wdata_s;
  assign dmem_be    = ctrl_m.MemW ? be_s : 4'b1111;

  // Writeback value selection.
  always_comb begin
    case (ctrl_m.ResultSelect)
      RESULT_ALU: result_sel_s = DataMemoryAddress_m;
      RESULT_MEM: result_sel_s = load_data_s;
      RESULT_PC4: result_sel_s = PC4_m;
      default:    result_sel_s = DataMemoryAddress_m;
    endcase
  end

  // MEM/WB next state: advance the instruction, or insert a bubble while stalled.
  always_comb begin
    valid_w_d    = 1'b0;
    ctrl_w_d     = ctrl_m;
    result_w_d   = result_w_q;
    misalign_w_d = 1'b0;
    if (stall_s) begin
      valid_w_d     = 1'b0;
      ctrl_w_d      = ctrl_m;
      ctrl_w_d.RegW = 1'b0;
      result_w_d    = result_w_q;
      misalign_w_d  = 1'b0;
    end else begin
      valid_w_d     = valid_m;
      ctrl_w_d      = ctrl_m;
      ctrl_w_d.RegW = ctrl_m.RegW & ~trap_s;
      result_w_d    = result_sel_s;
      misalign_w_d  = trap_s;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_w_q    <= 1'b0;
      result_w_q   <= 32'h0000_0000;
      ctrl_w_q     <= CTRL_RESET;
      misalign_w_q <= 1'b0;
    end else begin
      valid_w_q    <= valid_w_d;
      result_w_q   <= result_w_d;
      ctrl_w_q     <= ctrl_w_d;
      misalign_w_q <= misalign_w_d;
    end
  end

  assign valid_w  = valid_w_q;
  assign Result_w = result_w_q;
  assign ctrl_w   = ctrl_w_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_w = misalign_w_q;
`else
  logic unused_misalign_s;
  assign unused_misalign_s = misalign_w_q ^ trap_s;
`endif

endmodule
